// File: rtl/key_seq_reader_pkg.sv
// key_pkg: shared types and constants for the protection-key reader.
//   key_state_e  - sequencer states (IDLE/UNLOCK/READ/FINISH)
//   *_SEL/*_IDLE - bus-window levels driven while the key is selected / idle
//   READ_NIB_DEF - default BA7..BA4 value used for read strobes
//   max2()       - elaboration-time helper for counter sizing
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNLOCK = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } key_state_e;

    // Bus-window decode levels seen by the key GAL
    localparam logic SSER_SEL  = 1'b0;
    localparam logic SSER_IDLE = 1'b1;
    localparam logic BA13_SEL  = 1'b0;
    localparam logic BA13_IDLE = 1'b1;
    localparam logic BA12_SEL  = 1'b1;
    localparam logic BA12_IDLE = 1'b0;
    localparam logic BR_W_READ = 1'b1;
    localparam logic BR_W_IDLE = 1'b0;

    localparam logic [3:0] NIB_IDLE     = 4'h0;
    localparam logic [3:0] READ_NIB_DEF = 4'h0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_seq_reader_if.sv
// key_seq_reader_if: bundle of the CPU-side control/result signals and the
// key device pins for key_seq_reader.
//   slave  - the reader itself (drives busy/done/result and the key pins)
//   master - the environment (CPU register block plus the key's SDRD pin)
interface key_seq_reader_if #(
    parameter int NBITS   = 16,
    parameter int SEQ_LEN = 4
);
    logic                 start;
    logic                 abort;
    logic [SEQ_LEN*4-1:0] unlock_seq;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [NBITS-1:0]     data_out;
    logic                 key_sser_n;
    logic                 key_ba13;
    logic                 key_ba12;
    logic [3:0]           key_ba_nib;
    logic                 key_br_w;
    logic                 key_clk;
    logic                 key_sdrd;

    modport slave (
        input  start, abort, unlock_seq, key_sdrd,
        output busy, done, aborted, data_out,
               key_sser_n, key_ba13, key_ba12, key_ba_nib, key_br_w, key_clk
    );

    modport master (
        output start, abort, unlock_seq, key_sdrd,
        input  busy, done, aborted, data_out,
               key_sser_n, key_ba13, key_ba12, key_ba_nib, key_br_w, key_clk
    );
endinterface

// File: rtl/key_seq_reader_access_timer.sv
// key_access_timer: phase generator for one key bus access.
// An access is SETUP_CYC cycles with key_clk low followed by STROBE_CYC
// cycles with key_clk high; accesses repeat back to back while i_run is high.
//   clk, rst        - system clock, synchronous active-high reset
//   i_run           - hold high to keep issuing accesses; low parks in SETUP
//   o_key_clk       - registered key clock (high during STROBE)
//   o_sample        - last SETUP cycle (cycle before key_clk rises)
//   o_access_done   - last STROBE cycle of an access
module key_access_timer
    import key_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_key_clk,
    output logic o_sample,
    output logic o_access_done
);
    localparam int TW = $clog2(max2(SETUP_CYC, STROBE_CYC) + 1);

    logic [TW-1:0] r_cnt;
    logic          r_strobe;
    logic          w_setup_end;
    logic          w_strobe_end;

    assign w_setup_end  = !r_strobe && (r_cnt == TW'(SETUP_CYC - 1));
    assign w_strobe_end =  r_strobe && (r_cnt == TW'(STROBE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            // Parking in SETUP/0 means the next run starts a fresh access
            // and key_clk can never be left high after an early exit.
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (w_setup_end) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
        end else if (w_strobe_end) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + TW'(1);
        end
    end

    assign o_key_clk     = r_strobe;
    assign o_sample      = w_setup_end;
    assign o_access_done = w_strobe_end;

endmodule

// File: rtl/key_seq_reader.sv
// key_seq_reader: drives the protection-key GAL bus window, issues the
// unlock nibble sequence, then reads NBITS serial SDRD bits MSB first.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - key_seq_reader_if.slave:
//              start/abort/unlock_seq in, busy/done/aborted/data_out out,
//              key_sser_n/ba13/ba12/ba_nib/br_w/key_clk out, key_sdrd in
module key_seq_reader
    import key_pkg::*;
#(
    parameter int         NBITS      = 16,
    parameter int         SEQ_LEN    = 4,
    parameter int         SETUP_CYC  = 2,
    parameter int         STROBE_CYC = 2,
    parameter logic [3:0] READ_NIB   = READ_NIB_DEF
) (
    input logic              clk,
    input logic              rst,
    key_seq_reader_if.slave  bus
);
    localparam int CW = $clog2(max2(NBITS, SEQ_LEN) + 1);

    key_state_e                r_state;
    key_state_e                w_next;
    logic [CW-1:0]             r_cnt;
    logic [SEQ_LEN-1:0][3:0]   r_seq;
    logic [NBITS-1:0]          r_data;
    logic                      r_aborted;
    logic                      r_abort_pend;

    logic                      w_active;
    logic                      w_next_active;
    logic                      w_last;
    logic                      w_key_clk;
    logic                      w_sample;
    logic                      w_acc_done;
    logic                      w_abort_req;
    logic [3:0]                w_unlock_nib;
    logic [NBITS-1:0]          w_shift;

    assign w_active      = (r_state == ST_UNLOCK) || (r_state == ST_READ);
    assign w_next_active = (w_next  == ST_UNLOCK) || (w_next  == ST_READ);
    assign w_last        = (r_state == ST_UNLOCK) ? (r_cnt == CW'(SEQ_LEN - 1))
                                                  : (r_cnt == CW'(NBITS - 1));
    // An abort seen during STROBE is remembered until the strobe ends.
    assign w_abort_req   = bus.abort || r_abort_pend;

    // Timer runs only while staying in an access state; it is parked on the
    // IDLE cycle so the first UNLOCK cycle is SETUP cycle 0.
    key_access_timer #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_run         (w_active && w_next_active),
        .o_key_clk     (w_key_clk),
        .o_sample      (w_sample),
        .o_access_done (w_acc_done)
    );

    generate
        if (NBITS > 1) begin : g_shift
            assign w_shift = {r_data[NBITS-2:0], bus.key_sdrd};
        end else begin : g_shift1
            assign w_shift = bus.key_sdrd;
        end
    endgenerate

    always_comb begin
        w_unlock_nib = NIB_IDLE;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (r_cnt == CW'(k)) w_unlock_nib = r_seq[k];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_UNLOCK;
            end
            ST_UNLOCK, ST_READ: begin
                // Abort with key_clk low leaves at once (no strobe issued);
                // with key_clk high the strobe is allowed to finish.
                if (bus.abort && !w_key_clk) begin
                    w_next = ST_FINISH;
                end else if (w_acc_done) begin
                    if (w_abort_req)
                        w_next = ST_FINISH;
                    else if (w_last)
                        w_next = (r_state == ST_UNLOCK) ? ST_READ : ST_FINISH;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_seq        <= '0;
            r_data       <= '0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                r_cnt        <= '0;
                r_abort_pend <= 1'b0;
                if (bus.start) begin
                    r_seq     <= bus.unlock_seq;
                    r_data    <= '0;
                    r_aborted <= 1'b0;
                end
            end else if (w_active) begin
                if (bus.abort && w_key_clk) r_abort_pend <= 1'b1;
                // Counter restarts on the UNLOCK->READ hand-off.
                if (w_acc_done) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                // An abort on the sample cycle exits before the strobe, so
                // that bit is not taken.
                if (r_state == ST_READ && w_sample && !bus.abort)
                    r_data <= w_shift;
                if (w_next == ST_FINISH && w_abort_req) r_aborted <= 1'b1;
            end
        end
    end

    assign bus.busy       = w_active;
    assign bus.done       = (r_state == ST_FINISH);
    assign bus.aborted    = r_aborted;
    assign bus.data_out   = r_data;
    assign bus.key_sser_n = w_active ? SSER_SEL  : SSER_IDLE;
    assign bus.key_ba13   = w_active ? BA13_SEL  : BA13_IDLE;
    assign bus.key_ba12   = w_active ? BA12_SEL  : BA12_IDLE;
    assign bus.key_br_w   = w_active ? BR_W_READ : BR_W_IDLE;
    assign bus.key_clk    = w_key_clk;
    assign bus.key_ba_nib = (r_state == ST_UNLOCK) ? w_unlock_nib :
                            (r_state == ST_READ)   ? READ_NIB     : NIB_IDLE;

endmodule

// File: tb/tb_key_seq_reader.sv
// Directed bench for key_seq_reader: a default-parameter instance with a
// key model returning 16'hC3A5 after a 4-nibble unlock, and a minimal
// instance (NBITS=SEQ_LEN=SETUP_CYC=STROBE_CYC=1).
module tb_key_seq_reader;

    logic clk;
    logic rst;

    key_seq_reader_if #(.NBITS(16), .SEQ_LEN(4)) a ();
    key_seq_reader_if #(.NBITS(1),  .SEQ_LEN(1)) b ();

    key_seq_reader #(.NBITS(16), .SEQ_LEN(4), .SETUP_CYC(2), .STROBE_CYC(2), .READ_NIB(4'h0))
        dut_a (.clk(clk), .rst(rst), .bus(a));
    key_seq_reader #(.NBITS(1), .SEQ_LEN(1), .SETUP_CYC(1), .STROBE_CYC(1), .READ_NIB(4'h0))
        dut_b (.clk(clk), .rst(rst), .bus(b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nmis = 0;

    // ---- key model A: 4 unlock strobes, then bits of 16'hC3A5 MSB first
    logic [15:0] a_word = 16'hC3A5;
    int          a_edges = 0;
    logic        a_pk = 1'b0;
    always @(negedge clk) begin
        if (a.key_sser_n) a_edges = 0;
        else if (a.key_clk && !a_pk) a_edges++;
        a_pk = a.key_clk;
        a.key_sdrd = (a_edges >= 4 && a_edges < 20) ? a_word[19 - a_edges] : 1'b0;
    end

    // ---- key model B: returns b_bit after its single unlock strobe
    logic b_bit = 1'b0;
    int   b_edges = 0;
    logic b_pk = 1'b0;
    always @(negedge clk) begin
        if (b.key_sser_n) b_edges = 0;
        else if (b.key_clk && !b_pk) b_edges++;
        b_pk = b.key_clk;
        b.key_sdrd = (b_edges >= 1) ? b_bit : ~b_bit;
    end

    // ---- bus monitor on instance A
    logic       mon_clr = 1'b0;
    logic [3:0] rise_nibs[$];
    int         stab_err = 0, tim_err = 0, sel_run = 0, sel_len = 0, lo_run = 0, hi_run = 0;
    logic       m_pk = 1'b0;
    logic [3:0] m_pn = 4'h0;
    always @(negedge clk) begin
        if (mon_clr) begin
            rise_nibs.delete();
            stab_err = 0; tim_err = 0; sel_run = 0; sel_len = 0; lo_run = 0; hi_run = 0;
        end else begin
            if (!a.key_sser_n) sel_run++;
            else if (sel_run != 0) begin sel_len = sel_run; sel_run = 0; end
            if (a.key_clk && !m_pk) begin
                rise_nibs.push_back(a.key_ba_nib);
                if (a.key_ba_nib != m_pn || a.key_sser_n) stab_err++;
                if (lo_run != 2) tim_err++;
                lo_run = 0; hi_run = 1;
            end else if (a.key_clk) begin
                hi_run++;
            end else begin
                if (m_pk && hi_run != 2) tim_err++;
                hi_run = 0;
                if (!a.key_sser_n) lo_run++; else lo_run = 0;
            end
        end
        m_pk = a.key_clk;
        m_pn = a.key_ba_nib;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Runs one transaction on A. Cycle 1 is the cycle start is high.
    task automatic run_a(input logic [15:0] seq, input int restart_at,
                         output int dcyc, output int ndone, output int busy_gap);
        int cyc;
        dcyc = 0; ndone = 0; busy_gap = 0;
        nxt(); mon_clr = 1'b1; a.start = 1'b1; a.unlock_seq = seq; cyc = 1;
        while (cyc < 300) begin
            smp();
            if (a.done) begin ndone++; if (dcyc == 0) dcyc = cyc; end
            if (cyc > 1 && ndone == 0 && !a.busy) busy_gap++;
            nxt();
            cyc++;
            mon_clr = 1'b0;
            a.start = (cyc == restart_at);
            if (cyc == restart_at) a.unlock_seq = 16'hFFFF;
            if (dcyc != 0 && cyc > dcyc + 4) break;
        end
        a.start = 1'b0;
    endtask

    task automatic run_b(input logic bit_v, output int dcyc, output logic dout);
        int cyc;
        dcyc = 0;
        nxt(); b_bit = bit_v; b.start = 1'b1; b.unlock_seq = 4'h7; cyc = 1;
        while (cyc < 50 && dcyc == 0) begin
            smp();
            if (b.done) dcyc = cyc;
            nxt();
            cyc++;
            b.start = 1'b0;
        end
        dout = b.data_out[0];
    endtask

    initial begin
        int dc, nd, bg;
        int rd_bad;
        logic bo;
        logic [15:0] nibs;

        rst = 1'b1;
        a.start = 1'b0; a.abort = 1'b0; a.unlock_seq = '0;
        b.start = 1'b0; b.abort = 1'b0; b.unlock_seq = '0;
        repeat (3) nxt();
        rst = 1'b0;
        smp();
        chk("rst_busy",    a.busy, 0);
        chk("rst_done",    a.done, 0);
        chk("rst_aborted", a.aborted, 0);
        chk("rst_data",    a.data_out, 0);
        chk("rst_pins",    {a.key_sser_n, a.key_ba13, a.key_ba12, a.key_br_w, a.key_clk}, 5'b11000);
        chk("rst_nib",     a.key_ba_nib, 0);

        // Normal transaction
        run_a(16'h9A52, 0, dc, nd, bg);
        nibs = {rise_nibs[3], rise_nibs[2], rise_nibs[1], rise_nibs[0]};
        rd_bad = 0;
        for (int i = 4; i < rise_nibs.size(); i++) if (rise_nibs[i] != 4'h0) rd_bad++;
        chk("t1_done_cycle", dc, 82);
        chk("t1_done_count", nd, 1);
        chk("t1_busy_gap",   bg, 0);
        chk("t1_data",       a.data_out, 16'hC3A5);
        chk("t1_strobes",    rise_nibs.size(), 20);
        chk("t1_unlock_nibs", nibs, 16'h9A52);
        chk("t1_read_nibs",  rd_bad, 0);
        chk("t1_addr_stable", stab_err, 0);
        chk("t1_clk_timing", tim_err, 0);
        chk("t1_select_len", sel_len, 80);

        // Second start 10 cycles in must be ignored
        run_a(16'h9A52, 11, dc, nd, bg);
        nibs = {rise_nibs[3], rise_nibs[2], rise_nibs[1], rise_nibs[0]};
        chk("t3_done_cycle", dc, 82);
        chk("t3_done_count", nd, 1);
        chk("t3_unlock_nibs", nibs, 16'h9A52);
        chk("t3_strobes",    rise_nibs.size(), 20);
        chk("t3_data",       a.data_out, 16'hC3A5);

        // Abort during the 5th read strobe (cycle 36, key_clk high)
        nxt(); a.start = 1'b1; a.unlock_seq = 16'h9A52;   // cycle 1
        nxt(); a.start = 1'b0;                            // cycle 2
        repeat (34) nxt();                                // cycle 36
        a.abort = 1'b1;
        smp();
        chk("t4_kclk_hi",     a.key_clk, 1);
        chk("t4_data_5bits",  a.data_out, 16'h0018);
        nxt(); a.abort = 1'b0;                            // cycle 37
        smp();
        chk("t4_strobe_held", {a.busy, a.key_clk}, 2'b11);
        nxt();                                            // cycle 38
        smp();
        chk("t4_done",        a.done, 1);
        chk("t4_aborted",     a.aborted, 1);
        chk("t4_data_hold",   a.data_out, 16'h0018);
        chk("t4_pins_idle",   {a.key_sser_n, a.key_ba13, a.key_ba12, a.key_br_w, a.key_clk, a.busy}, 6'b110000);
        chk("t4_nib_idle",    a.key_ba_nib, 0);
        nxt();                                            // cycle 39
        smp();
        chk("t4_single_done", a.done, 0);
        chk("t4_aborted_sticky", a.aborted, 1);

        // Reset mid-UNLOCK (cycle 8: access 1 strobe)
        nxt(); a.start = 1'b1;                            // cycle 1
        nxt(); a.start = 1'b0;                            // cycle 2
        smp();
        chk("t5_aborted_cleared", a.aborted, 0);
        repeat (6) nxt();                                 // cycle 8
        rst = 1'b1;
        smp();
        chk("t5_pre_kclk",    {a.key_sser_n, a.key_clk}, 2'b01);
        nxt(); rst = 1'b0;                                // cycle 9
        smp();
        chk("t5_pins_idle",   {a.key_sser_n, a.key_clk, a.busy, a.done}, 4'b1000);
        chk("t5_data",        a.data_out, 0);
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            nxt(); smp();
            if (a.done) nd++;
        end
        chk("t5_no_done",     nd, 0);

        // Minimal configuration
        run_b(1'b1, dc, bo);
        chk("t6_done_cycle1", dc, 6);
        chk("t6_data1",       bo, 1'b1);
        run_b(1'b0, dc, bo);
        chk("t6_done_cycle0", dc, 6);
        chk("t6_data0",       bo, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/key_seq_reader.md
Name: key_seq_reader

Overview:
- Host-side sequencer that drives the protection-key GAL's bus-window decode inputs and assembles its serial SDRD output into a parallel word.
- Issues a programmable nibble unlock sequence to advance the key's internal state machine, then issues NBITS read strobes, sampling SDRD once per strobe.
- Sits between the CPU-side control register block (start, unlock sequence, result) and the key device pins (SSER, BA13, BA12, BA7..BA4, BR_W, key clock, SDRD).

Parameters:
- NBITS, 16, number of serial bits read after unlock (1..32)
- SEQ_LEN, 4, number of unlock nibbles issued (1..8)
- SETUP_CYC, 2, clk cycles the address is held with key_clk low before each rising edge (>=1)
- STROBE_CYC, 2, clk cycles key_clk is held high per access (>=1)
- READ_NIB, 4'h0, BA7..BA4 value driven during read strobes

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- start  in  1  one-cycle pulse; begins a transaction when idle
- abort  in  1  terminates a transaction in progress
- unlock_seq  in  SEQ_LEN*4  unlock nibbles; nibble 0 is in bits [3:0] and is issued first
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end (normal or aborted)
- aborted  out  1  sticky; set when the last transaction was aborted, cleared on start
- data_out  out  NBITS  assembled key word
- key_sser_n  out  1  key select (SSER), active low
- key_ba13  out  1  driven 0 while selected, 1 when idle
- key_ba12  out  1  driven 1 while selected, 0 when idle
- key_ba_nib  out  4  BA7..BA4
- key_br_w  out  1  driven 1 (read) while selected
- key_clk  out  1  clock to the key registers
- key_sdrd  in  1  serial data from the key, pre-synchronised externally

Behaviour:
- Reset and IDLE values: key_sser_n=1, key_ba13=1, key_ba12=0, key_ba_nib=0, key_br_w=0, key_clk=0, busy=0, done=0, aborted=0, data_out=0.
- FSM states: IDLE, UNLOCK, READ, FINISH.
- IDLE:
  - start=1 latches unlock_seq and clears data_out and aborted.
  - Next state is UNLOCK with busy=1.
  - start while busy is ignored.
- Access unit (used by UNLOCK and READ):
  - Phase SETUP: SETUP_CYC cycles with key_sser_n=0, key_ba13=0, key_ba12=1, key_br_w=1, nibble driven, key_clk=0.
  - Phase STROBE: STROBE_CYC cycles with key_clk=1 and the address held.
  - One access = SETUP_CYC+STROBE_CYC cycles. The select window stays asserted between consecutive accesses; no idle gap.
- UNLOCK:
  - Issues SEQ_LEN accesses with key_ba_nib = unlock nibble k, for k = 0..SEQ_LEN-1.
  - key_sdrd is ignored.
- READ:
  - Issues NBITS accesses with key_ba_nib=READ_NIB.
  - key_sdrd is sampled on the last SETUP cycle of each access, i.e. the clk cycle before key_clk rises, while the key drives the bit for its current state.
  - Sampled bits are shifted in MSB first: data_out <= {data_out[NBITS-2:0], key_sdrd}. data_out therefore updates only during READ.
- FINISH:
  - One cycle: all key outputs return to IDLE values, done=1, busy=0.
  - Next state is IDLE.
- Latency: start to done = 1 + (SEQ_LEN+NBITS)*(SETUP_CYC+STROBE_CYC) + 1 cycles; 82 with defaults.
- abort:
  - Sampled in UNLOCK or READ. Completes the current phase only if key_clk is already high (no glitched strobe), otherwise exits immediately.
  - Then goes to FINISH with aborted=1. data_out holds the partial word.
  - abort together with start in IDLE: start wins, abort is ignored.
- Bit and access counters:
  - Width is $clog2(max(NBITS,SEQ_LEN)+1).
  - The counter resets on each state entry and reaches its terminal count exactly at SEQ_LEN-1 or NBITS-1; no wrap-around.
- key_clk comes from a registered FSM output only; it is never combinational from inputs.
- rst mid-transaction: all outputs return to reset values on the next clk edge with no FINISH/done pulse. The key's internal state is not reset; software re-runs the unlock sequence.

Decomposition:
- Shared package key_pkg holds:
  - the state enum (IDLE/UNLOCK/READ/FINISH)
  - the bus-window constants (BA13 select=0, BA12 select=1, BR_W read=1)
  - the default READ_NIB
- One sub-module, key_access_timer: generates the SETUP/STROBE phase, key_clk, the sample strobe, and an access_done pulse from SETUP_CYC/STROBE_CYC. The top-level FSM counts accesses and selects the nibble.

Test Plan:
- Defaults, unlock_seq=16'h9A52, key model returns 16'hC3A5 → nibbles on key_ba_nib in order 2,5,A,9; 16 read strobes; data_out=16'hC3A5; done pulses exactly 82 cycles after start; busy high throughout.
- Strobe timing → key_clk low exactly 2 cycles and high exactly 2 cycles per access; address stable across each key_clk rising edge; key_sser_n low continuously for 80 cycles.
- start pulsed again 10 cycles into a transaction → ignored; a single done; bus sequence unchanged.
- abort asserted in READ after 5 bits while key_clk high → strobe completes, FINISH next; aborted=1; data_out holds the 5 sampled bits right-aligned; key outputs return to idle values.
- rst asserted mid-UNLOCK → next cycle key_sser_n=1, key_clk=0, busy=0, data_out=0; no done pulse.
- NBITS=1, SEQ_LEN=1, SETUP_CYC=1, STROBE_CYC=1 → 2 accesses; done 6 cycles after start; data_out equals key_sdrd sampled on the second access.
